// File: rtl/ddr_stream_writer.sv
// Stream-to-AXI write master feeding ddr_trans: buffers a valid/ready word stream and issues write bursts.
// Optional idle auto-flush of partial bursts: DDR_STREAM_WR_AUTO_FLUSH_EN.
module ddr_stream_writer #(
  parameter int BA_BITS   = 2,
  parameter int ROW_BITS  = 13,
  parameter int COL_BITS  = 11,
  parameter int DQ_LEVEL  = 1,
  parameter int BURST_LEN = 16,
  parameter int FIFO_AW   = 6,
  localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
  localparam int DW = 8 << DQ_LEVEL
) (
  input  logic          core_clk,
  input  logic          core_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_flush,
  output logic          o_busy,
  output logic          awvalid,
  input  logic          awready,
  output logic [AW-1:0] awaddr,
  output logic [7:0]    awlen,
  output logic          wvalid,
  input  logic          wready,
  output logic          wlast,
  output logic [DW-1:0] wdata,
  input  logic          bvalid,
  output logic          bready
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] BURST_CNT = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_idx, rd_idx;
  logic [FIFO_AW:0]    count;
  logic [AW-1:0]       ptr, step;
  logic [7:0]          len_m1, beat;
  logic                flush_pending, auto_flush;
  logic                push, pop, fifo_full, fifo_empty;
  logic                start_ok, take_full, take_flush;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign i_ready    = !fifo_full;
  assign push       = i_valid && i_ready;
  assign pop        = wvalid && wready;
  assign o_busy     = (state != S_IDLE) || !fifo_empty;
  assign awaddr     = ptr;
  assign awlen      = len_m1;
  assign wdata      = mem[rd_idx];
  // Byte stride of the burst just completed; wraps naturally in AW bits.
  assign step       = AW'({1'b0, len_m1} + 9'd1) << DQ_LEVEL;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_ok   = 1'b0;
    take_full  = 1'b0;
    take_flush = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start && fifo_empty) begin
          start_ok = 1'b1;
        end else if (count >= BURST_CNT) begin
          take_full = 1'b1;
          state_nxt = S_AW;
        end else if (flush_pending && !fifo_empty) begin
          take_flush = 1'b1;
          state_nxt  = S_AW;
        end
      end
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_nxt = S_W;
      end
      S_W: begin
        wvalid = 1'b1;
        wlast  = (beat == len_m1);
        if (wready && wlast) state_nxt = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (push) mem[wr_idx] <= i_data;
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      wr_idx        <= '0;
      rd_idx        <= '0;
      count         <= '0;
      ptr           <= '0;
      len_m1        <= '0;
      beat          <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (start_ok)                     ptr <= i_base;
      else if (state == S_B && bvalid)  ptr <= ptr + step;

      // Burst length is latched at the issue decision so count may keep growing.
      if (take_full)       len_m1 <= 8'(BURST_LEN - 1);
      else if (take_flush) len_m1 <= 8'(count - 1'b1);

      if (pop) beat <= wlast ? 8'd0 : beat + 8'd1;

      if (i_flush || auto_flush)              flush_pending <= 1'b1;
      else if (state == S_IDLE && fifo_empty) flush_pending <= 1'b0;
    end
  end

`ifdef DDR_STREAM_WR_AUTO_FLUSH_EN
  logic [9:0] idle_cnt;

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      idle_cnt <= '0;
    end else if (state != S_IDLE || push) begin
      idle_cnt <= '0;
    end else if (!fifo_empty && count < BURST_CNT && idle_cnt != 10'd1023) begin
      idle_cnt <= idle_cnt + 10'd1;
    end
  end

  assign auto_flush = (idle_cnt == 10'd1023);
`else
  assign auto_flush = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_stream_writer.sv
// Directed bench for ddr_stream_writer: scoreboard of pushed words and expected bursts, checked every cycle.
module tb_ddr_stream_writer;
  localparam int AW = 26;
  localparam int DW = 16;

  logic          core_clk = 1'b0;
  logic          core_rst;
  logic          i_start, i_valid, i_ready, i_flush, o_busy;
  logic [AW-1:0] i_base, awaddr;
  logic [DW-1:0] i_data, wdata;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [7:0]    awlen;

  ddr_stream_writer dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .i_start(i_start), .i_base(i_base),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_flush(i_flush), .o_busy(o_busy),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready)
  );

  initial forever #5 core_clk = ~core_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int b_done = 0;
  int w_beat = 0;
  int cur_len = 1;
  logic stall = 1'b0;

  logic [DW-1:0]      exp_q[$];
  logic [AW+7:0]      burst_q[$];   // {addr, len-1}
  logic               aw_stall_p = 1'b0, w_stall_p = 1'b0;
  logic [AW-1:0]      sv_awaddr;
  logic [7:0]         sv_awlen;
  logic [DW-1:0]      sv_wdata;
  logic               sv_wlast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h want event", name, act);
  endtask

  // Scoreboard: compares on the low clock phase; handshakes seen here complete at the next rising edge.
  initial forever begin
    logic [AW+7:0] e;
    @(negedge core_clk);
    if (core_rst) begin
      exp_q.delete();
      aw_stall_p = 1'b0;
      w_stall_p  = 1'b0;
      w_beat     = 0;
    end else begin
      check("i_ready", i_ready, exp_q.size() < 64);
      if (aw_stall_p) begin
        check("aw_hold_valid", awvalid, 1'b1);
        check("aw_hold_addr", awaddr, sv_awaddr);
        check("aw_hold_len", awlen, sv_awlen);
      end
      if (w_stall_p) begin
        check("w_hold_valid", wvalid, 1'b1);
        check("w_hold_data", wdata, sv_wdata);
        check("w_hold_last", wlast, sv_wlast);
      end
      if (awvalid && awready) begin
        if (burst_q.size() > 0) begin
          e = burst_q.pop_front();
          check("awaddr", awaddr, e[AW+7:8]);
          check("awlen", awlen, e[7:0]);
          cur_len = int'(e[7:0]) + 1;
          w_beat  = 0;
        end else begin
          fail_now("aw_unexpected", {awaddr, awlen});
        end
      end
      if (wvalid) begin
        check("w_data_present", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("wdata", wdata, exp_q[0]);
        check("wlast", wlast, w_beat == cur_len - 1);
      end
      if (wvalid && wready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        w_beat++;
        if (w_beat == cur_len) w_beat = 0;
      end
      if (i_valid && i_ready) exp_q.push_back(i_data);
      if (bvalid && bready) b_done++;
      aw_stall_p = awvalid && !awready;
      w_stall_p  = wvalid && !wready;
      sv_awaddr  = awaddr;
      sv_awlen   = awlen;
      sv_wdata   = wdata;
      sv_wlast   = wlast;
    end
  end

  initial forever begin
    @(posedge core_clk);
    #1;
    if (stall) begin
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    int t = 0;
    i_valid = 1'b1;
    i_data  = d;
    @(negedge core_clk);
    while (!i_ready && t < 2000) begin
      @(negedge core_clk);
      t++;
    end
    if (t >= 2000) fail_now("push_timeout", d);
    @(posedge core_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_b(input int n);
    int t = 0;
    while (b_done < n && t < 5000) begin
      @(negedge core_clk);
      t++;
    end
    if (b_done < n) fail_now("bresp_timeout", b_done);
    @(posedge core_clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge core_clk);
    while (o_busy && t < 5000) begin
      @(negedge core_clk);
      t++;
    end
    if (o_busy) fail_now("idle_timeout", o_busy);
    @(posedge core_clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    i_start = 1'b1;
    i_base  = base;
    @(posedge core_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic do_flush();
    i_flush = 1'b1;
    @(posedge core_clk);
    #1;
    i_flush = 1'b0;
  endtask

  initial begin
    int t;
    core_rst = 1'b1;
    i_start = 1'b0; i_base = '0; i_valid = 1'b0; i_data = '0; i_flush = 1'b0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_awaddr", awaddr, '0);
    check("rst_awlen", awlen, '0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_wlast", wlast, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_ready", i_ready, 1'b1);
    core_rst = 1'b0;
    @(posedge core_clk);
    #1;

    // Full burst from a fresh base.
    do_start(26'h100);
    burst_q.push_back({26'h100, 8'd15});
    for (int i = 0; i < 16; i++) push_word(16'(i));
    wait_b(1);
    wait_idle();
    check("t1_bursts", b_done, 1);

    // Partial burst only on flush.
    for (int i = 0; i < 5; i++) push_word(16'h200 + 16'(i));
    repeat (20) @(posedge core_clk);
    #1;
    check("t2_no_early_aw", awvalid, 1'b0);
    check("t2_busy_buffered", o_busy, 1'b1);
    burst_q.push_back({26'h120, 8'd4});
    do_flush();
    wait_b(2);
    wait_idle();
    repeat (10) @(posedge core_clk);
    #1;
    check("t2_flush_cleared", awvalid, 1'b0);
    check("t2_busy_after", o_busy, 1'b0);

    // Random back-pressure on aw/w with a continuous 40-word stream.
    burst_q.push_back({26'h12A, 8'd15});
    burst_q.push_back({26'h14A, 8'd15});
    stall = 1'b1;
    for (int i = 0; i < 40; i++) push_word(16'h300 + 16'(i));
    wait_b(4);
    stall = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    repeat (5) @(posedge core_clk);
    #1;
    check("t3_remaining", exp_q.size(), 8);
    check("t3_busy", o_busy, 1'b1);
    check("t3_idle_no_aw", awvalid, 1'b0);
    burst_q.push_back({26'h16A, 8'd7});
    do_flush();
    wait_b(5);
    wait_idle();

    // Fill the FIFO behind a stalled address channel.
    awready = 1'b0;
    for (int k = 0; k < 4; k++) burst_q.push_back({26'h17A + 26'(k * 32), 8'd15});
    for (int i = 0; i < 64; i++) push_word(16'h400 + 16'(i));
    @(negedge core_clk);
    check("t4_full_ready", i_ready, 1'b0);
    check("t4_aw_waiting", awvalid, 1'b1);
    @(posedge core_clk);
    #1;
    awready = 1'b1;
    t = 0;
    @(negedge core_clk);
    while (!(wvalid && wready) && t < 100) begin
      @(negedge core_clk);
      t++;
    end
    if (t >= 100) fail_now("t4_first_pop_timeout", t);
    @(negedge core_clk);
    check("t4_ready_after_pop", i_ready, 1'b1);
    wait_b(9);
    wait_idle();

    // Address wrap at the top of DDR space.
    do_start(26'h3FFFFE0);
    burst_q.push_back({26'h3FFFFE0, 8'd15});
    burst_q.push_back({26'h0, 8'd15});
    for (int i = 0; i < 32; i++) push_word(16'h500 + 16'(i));
    wait_b(11);
    wait_idle();

    // Asynchronous reset in the middle of the data phase.
    burst_q.push_back({26'h20, 8'd15});
    for (int i = 0; i < 16; i++) push_word(16'h600 + 16'(i));
    t = 0;
    @(negedge core_clk);
    #1;
    while (!(wvalid && w_beat == 8) && t < 200) begin
      @(negedge core_clk);
      #1;
      t++;
    end
    if (t >= 200) fail_now("t6_beat7_timeout", t);
    core_rst = 1'b1;
    #1;
    check("t6_awvalid", awvalid, 1'b0);
    check("t6_awaddr", awaddr, '0);
    check("t6_awlen", awlen, '0);
    check("t6_wvalid", wvalid, 1'b0);
    check("t6_wlast", wlast, 1'b0);
    check("t6_bready", bready, 1'b0);
    check("t6_busy", o_busy, 1'b0);
    check("t6_ready", i_ready, 1'b1);
    @(posedge core_clk);
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;
    @(posedge core_clk);
    #1;
    burst_q.push_back({26'h0, 8'd15});
    for (int i = 0; i < 16; i++) push_word(16'h700 + 16'(i));
    wait_b(12);
    wait_idle();
    check("bursts_consumed", burst_q.size(), 0);
    check("fifo_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
